// File: rtl/kbd_cmd_pkg.sv
// rtl/kbd_cmd_pkg.sv - shared types and defaults for the keyboard command controller
// Holds the command code enum (cmd_t), the controller state enum (state_t),
// the default restart acknowledge timeout, and the key priority encoder.
package kbd_cmd_pkg;

    localparam int ACK_TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_STOP    = 3'd1,
        CMD_PLAY    = 3'd2,
        CMD_FWD     = 3'd3,
        CMD_BWD     = 3'd4,
        CMD_RESTART = 3'd5
    } cmd_t;

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_PLAYING = 2'd1,
        ST_RESTART = 2'd2
    } state_t;

    // Key edge vector layout: {r, d, e, f, b}. Highest-priority edge wins,
    // all others in the same cycle are dropped.
    function automatic cmd_t pick_cmd(input logic [4:0] rises);
        if (rises[4])      return CMD_RESTART;
        else if (rises[3]) return CMD_STOP;
        else if (rises[2]) return CMD_PLAY;
        else if (rises[1]) return CMD_FWD;
        else if (rises[0]) return CMD_BWD;
        else               return CMD_NONE;
    endfunction

endpackage

// File: rtl/sync_rise.sv
// rtl/sync_rise.sv - 2-flop synchronizer plus registered rising-edge detector
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   d     - asynchronous level input
//   rise  - one-cycle pulse, high after the edge two cycles past the edge
//           that first sampled d=1 following d=0
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic meta;
    logic sync;
    logic hist;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            hist <= 1'b0;
            rise <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
            hist <= sync;
            // Registered so the controller acts exactly three edges after
            // the key was first sampled high.
            rise <= sync & ~hist;
        end
    end

endmodule

// File: rtl/kbd_cmd_ctrl.sv
// rtl/kbd_cmd_ctrl.sv - keyboard command controller for playback/restart control
// Ports:
//   clk, rst_n                         - clock, synchronous active-low reset
//   key_d/key_e/key_b/key_f/key_r      - async decoded key levels (stop/play/back/fwd/restart)
//   restart_ack                        - restart confirmation from address generator
//   play, dir_fwd                      - playback running flag, direction (1 = forward)
//   restart_req, restart_err           - restart handshake request, sticky timeout flag
//   cmd_valid, last_cmd                - accepted-command pulse and its code
module kbd_cmd_ctrl
    import kbd_cmd_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_d,
    input  logic       key_e,
    input  logic       key_b,
    input  logic       key_f,
    input  logic       key_r,
    input  logic       restart_ack,
    output logic       play,
    output logic       dir_fwd,
    output logic       restart_req,
    output logic       restart_err,
    output logic       cmd_valid,
    output logic [2:0] last_cmd
);

    // Timeout fires on the edge where the counter would reach ACK_TIMEOUT.
    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    logic [4:0] keys;
    logic [4:0] rises;
    cmd_t       cmd;

    state_t     state, state_n;
    logic       prior_play, prior_play_n;
    logic       dir_q, dir_n;
    logic       err_q, err_n;
    logic       valid_q, valid_n;
    cmd_t       last_q, last_n;
    logic [7:0] wait_cnt, wait_n;

    assign keys = {key_r, key_d, key_e, key_f, key_b};

    for (genvar i = 0; i < 5; i++) begin : g_key
        sync_rise u_sync_rise (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (keys[i]),
            .rise  (rises[i])
        );
    end

    assign cmd = pick_cmd(rises);

    // State and datapath register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_PAUSED;
            prior_play <= 1'b0;
            dir_q      <= 1'b1;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= CMD_NONE;
            wait_cnt   <= 8'd0;
        end else begin
            state      <= state_n;
            prior_play <= prior_play_n;
            dir_q      <= dir_n;
            err_q      <= err_n;
            valid_q    <= valid_n;
            last_q     <= last_n;
            wait_cnt   <= wait_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n      = state;
        prior_play_n = prior_play;
        dir_n        = dir_q;
        err_n        = err_q;
        valid_n      = 1'b0;
        last_n       = last_q;
        wait_n       = wait_cnt;

        case (state)
            ST_PAUSED, ST_PLAYING: begin
                if (cmd != CMD_NONE) begin
                    valid_n = 1'b1;
                    last_n  = cmd;
                    case (cmd)
                        CMD_RESTART: begin
                            state_n      = ST_RESTART;
                            prior_play_n = (state == ST_PLAYING);
                            wait_n       = 8'd0;
                        end
                        CMD_STOP: state_n = ST_PAUSED;
                        CMD_PLAY: state_n = ST_PLAYING;
                        CMD_FWD:  dir_n   = 1'b1;
                        CMD_BWD:  dir_n   = 1'b0;
                        default:  ;
                    endcase
                end
            end
            ST_RESTART: begin
                // Key edges are swallowed here; ack wins over a coincident timeout.
                if (restart_ack) begin
                    state_n = prior_play ? ST_PLAYING : ST_PAUSED;
                end else begin
                    wait_n = wait_cnt + 8'd1;
                    if (wait_cnt == TIMEOUT_LAST) begin
                        err_n   = 1'b1;
                        state_n = prior_play ? ST_PLAYING : ST_PAUSED;
                    end
                end
            end
            default: state_n = ST_PAUSED;
        endcase
    end

    // Output logic
    always_comb begin
        play        = (state == ST_PLAYING) || ((state == ST_RESTART) && prior_play);
        restart_req = (state == ST_RESTART);
        dir_fwd     = dir_q;
        restart_err = err_q;
        cmd_valid   = valid_q;
        last_cmd    = last_q;
    end

endmodule

// File: tb/tb_kbd_cmd_ctrl.sv
// tb/tb_kbd_cmd_ctrl.sv - randomized self-checking bench for kbd_cmd_ctrl
module tb_kbd_cmd_ctrl;

    localparam int TO   = 8;
    localparam int NCYC = 4000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_d, key_e, key_b, key_f, key_r;
    logic       restart_ack;
    logic       play, dir_fwd, restart_req, restart_err, cmd_valid;
    logic [2:0] last_cmd;

    always #5 clk = ~clk;

    kbd_cmd_ctrl #(.ACK_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_d       (key_d),
        .key_e       (key_e),
        .key_b       (key_b),
        .key_f       (key_f),
        .key_r       (key_r),
        .restart_ack (restart_ack),
        .play        (play),
        .dir_fwd     (dir_fwd),
        .restart_req (restart_req),
        .restart_err (restart_err),
        .cmd_valid   (cmd_valid),
        .last_cmd    (last_cmd)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp, input int cyc);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Reference model: 0 = paused, 1 = playing, 2 = waiting for restart ack
    int       m_mode;
    bit       m_prior;
    bit       m_dir;
    bit       m_err;
    bit       m_valid;
    int       m_last;
    int       m_wait;
    bit [4:0] hist [0:NCYC-1];
    int       last_rst;
    int       n_timeouts;
    int       n_cmds;

    // Key levels sampled at edge x; nothing sampled at or before a reset edge counts.
    function automatic bit [4:0] hv(input int x);
        if (x < 0 || x <= last_rst) return 5'd0;
        return hist[x];
    endfunction

    task automatic model_edge(input int n, input bit rst, input bit [4:0] kv, input bit ack);
        bit [4:0] rises;
        hist[n] = kv;
        if (!rst) begin
            last_rst = n;
            m_mode = 0; m_prior = 0; m_dir = 1; m_err = 0;
            m_valid = 0; m_last = 0; m_wait = 0;
            return;
        end
        m_valid = 0;
        // A key first seen high at edge k (after being low) acts at edge k+3.
        rises = hv(n - 3) & ~hv(n - 4);
        if (m_mode == 2) begin
            if (ack) begin
                m_mode = m_prior ? 1 : 0;
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_err = 1;
                    n_timeouts++;
                    m_mode = m_prior ? 1 : 0;
                end
            end
        end else if (rises != 0) begin
            m_valid = 1;
            n_cmds++;
            if (rises[4]) begin
                m_last = 5; m_prior = (m_mode == 1); m_mode = 2; m_wait = 0;
            end else if (rises[3]) begin
                m_last = 1; m_mode = 0;
            end else if (rises[2]) begin
                m_last = 2; m_mode = 1;
            end else if (rises[1]) begin
                m_last = 3; m_dir = 1;
            end else begin
                m_last = 4; m_dir = 0;
            end
        end
    endtask

    initial begin
        bit [4:0] kv;
        bit       ack;
        bit       rst;
        kv = 5'd0;
        last_rst = -1;
        n_timeouts = 0;
        n_cmds = 0;
        rst_n = 1'b0;
        {key_r, key_d, key_e, key_f, key_b} = 5'd0;
        restart_ack = 1'b0;

        for (int n = 0; n < NCYC; n++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(5) == 0) kv[b] = ~kv[b];
            ack = ($urandom_range(9) == 0);
            rst = !(n < 2 || $urandom_range(299) == 0);
            rst_n = rst;
            {key_r, key_d, key_e, key_f, key_b} = kv;
            restart_ack = ack;

            @(posedge clk);
            model_edge(n, rst, kv, ack);
            @(negedge clk);

            chk("play",        {7'd0, play},        {7'd0, (m_mode == 1) || (m_mode == 2 && m_prior)}, n);
            chk("dir_fwd",     {7'd0, dir_fwd},     {7'd0, m_dir},  n);
            chk("restart_req", {7'd0, restart_req}, {7'd0, m_mode == 2}, n);
            chk("restart_err", {7'd0, restart_err}, {7'd0, m_err},  n);
            chk("cmd_valid",   {7'd0, cmd_valid},   {7'd0, m_valid}, n);
            chk("last_cmd",    {5'd0, last_cmd},    8'(m_last),     n);
        end

        chk("timeouts_seen", 8'(n_timeouts > 0), 8'd1, NCYC);
        chk("cmds_seen",     8'(n_cmds > 20),    8'd1, NCYC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
